// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// Entry layout is the default 32/32 slice; the top rebuilds it when resized.
package fetch_pkg;
    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;
    localparam logic [31:0] DEF_PC_INC = 32'd4;
    localparam logic [31:0] DEF_RESET_PC = 32'h0;

    typedef struct packed {
        logic [DEF_ADDR_W-1:0] pc;
        logic [DEF_INST_W-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_if.sv
// Fetch unit bus: imem request/response plus decode valid/ready.
// master = fetch unit side, slave = memory/decode side.
interface fetch_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_gnt;
    logic              imem_rvalid;
    logic [INST_W-1:0] imem_rdata;
    logic              out_valid;
    logic              out_ready;
    logic [INST_W-1:0] out_inst;
    logic [ADDR_W-1:0] out_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_gnt, imem_rvalid, imem_rdata,
        output out_valid, out_inst, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_gnt, imem_rvalid, imem_rdata,
        input  out_valid, out_inst, out_pc,
        output out_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with flush, occupancy count and registered head.
// Storage is reset so the head reads zero out of reset.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  entry_t        wdata,
    input  logic          pop,
    output logic          valid,
    output entry_t        head,
    output logic [CW-1:0] count
);
    entry_t        mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic          empty;
    logic          full;
    logic          do_pop;

    assign empty  = (count == '0);
    assign full   = (count == CW'(DEPTH));
    assign do_pop = pop && !empty;
    assign valid  = !empty;
    assign head   = mem[rptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= wdata;
                wptr      <= wptr + 1'b1;
            end
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(push) - CW'(do_pop);
        end
    end

    // A full push is only legal when the head leaves in the same cycle.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (!rst_n)
        !(push && full && !pop)
    );
endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: pipelined imem requests, prefetch FIFO, redirect flush.
// Credits (outstanding + buffered) never exceed DEPTH.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W,
    parameter logic [ADDR_W-1:0] PC_INC = ADDR_W'(DEF_PC_INC),
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEF_RESET_PC),
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    fetch_if.master           bus
);
    localparam int CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } entry_t;

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] resp_pc;
    logic [CW-1:0]     outstanding;
    logic [CW-1:0]     outst_d;
    logic [CW-1:0]     drop_cnt;
    logic [CW-1:0]     fifo_count;
    logic              credit_ok;
    logic              req;
    logic              fire;
    logic              drop;
    logic              push;
    logic              pop;
    logic              fifo_valid;
    entry_t            wdata;
    entry_t            head;

    assign credit_ok = (outstanding + fifo_count) < CW'(DEPTH);

    always_comb begin
        state_d = state_q;
        req     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_en) state_d = RUN;
            end
            RUN: begin
                if (!fetch_en) state_d = IDLE;
                req = !redirect_valid && credit_ok;
            end
            default: state_d = IDLE;
        endcase
    end

    assign fire    = req && bus.imem_gnt;
    // A response landing in the redirect cycle belongs to the old stream.
    assign drop    = bus.imem_rvalid
                  && (redirect_valid || drop_cnt != '0);
    assign push    = bus.imem_rvalid && !drop;
    assign pop     = fifo_valid && bus.out_ready;
    assign outst_d = outstanding + CW'(fire) - CW'(bus.imem_rvalid);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            outstanding <= outst_d;
            if (redirect_valid) begin
                pc_q     <= redirect_pc;
                resp_pc  <= redirect_pc;
                drop_cnt <= outst_d;
            end else begin
                if (fire) pc_q <= pc_q + PC_INC;
                if (push) resp_pc <= resp_pc + PC_INC;
                if (drop) drop_cnt <= drop_cnt - 1'b1;
            end
        end
    end

    assign wdata.pc   = resp_pc;
    assign wdata.inst = bus.imem_rdata;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .valid (fifo_valid),
        .head  (head),
        .count (fifo_count)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = pc_q;
    assign bus.out_valid = fifo_valid;
    assign bus.out_inst  = head.inst;
    assign bus.out_pc    = head.pc;
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table plus redirect/halt/wrap sequences.
// Memory models return addr ^ KEY after a programmable latency.
module tb_fetch_unit;
    localparam logic [31:0] KEY = 32'hC0DE_5A00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fen;
    logic        rv;
    logic        wen;
    logic        rdy;
    logic [31:0] rpc;
    logic [2:0]  li;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    fetch_if #(.ADDR_W(32), .INST_W(32)) bus ();
    fetch_if #(.ADDR_W(32), .INST_W(32)) wbus ();

    fetch_unit #(.DEPTH(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fen),
        .redirect_valid (rv),
        .redirect_pc    (rpc),
        .bus            (bus)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) wdut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (wen),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .bus            (wbus)
    );

    logic        sv [8];
    logic [31:0] sa [8];
    logic        wv;
    logic [31:0] wa;

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                sv[i] <= 1'b0;
                sa[i] <= 32'h0;
            end
            wv <= 1'b0;
            wa <= 32'h0;
        end else begin
            sv[0] <= bus.imem_req & bus.imem_gnt;
            sa[0] <= bus.imem_addr;
            for (int i = 1; i < 8; i++) begin
                sv[i] <= sv[i-1];
                sa[i] <= sa[i-1];
            end
            wv <= wbus.imem_req & wbus.imem_gnt;
            wa <= wbus.imem_addr;
        end
    end

    assign bus.imem_gnt    = 1'b1;
    assign bus.imem_rvalid = sv[li];
    assign bus.imem_rdata  = sa[li] ^ KEY;
    assign bus.out_ready   = rdy;
    assign wbus.imem_gnt    = 1'b1;
    assign wbus.imem_rvalid = wv;
    assign wbus.imem_rdata  = wa ^ KEY;
    assign wbus.out_ready   = 1'b1;

    typedef struct {
        logic        fen;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        vld;
        logic [31:0] pc;
    } vec_t;

    vec_t        tbl [22];
    logic [31:0] got [$];
    logic [31:0] gin [$];

    function automatic vec_t mk(logic r, logic q, logic [31:0] a,
                                logic v, logic [31:0] p);
        vec_t t;
        t.fen  = 1'b1;
        t.rdy  = r;
        t.req  = q;
        t.addr = a;
        t.vld  = v;
        t.pc   = p;
        return t;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic wait_vld(string nm, output int n);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        total++;
        if (!bus.out_valid) begin
            bad++;
            $display("FAIL %s: out_valid 0 after %0d cycles, want 1", nm, n);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        fen = 1'b0;
        rv = 1'b0;
        rdy = 1'b1;
        wen = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;

        tbl[0] = mk(1, 0, 32'h00, 0, 32'h00);
        tbl[1] = mk(1, 1, 32'h00, 0, 32'h00);
        tbl[2] = mk(1, 1, 32'h04, 0, 32'h00);
        tbl[3] = mk(1, 1, 32'h08, 1, 32'h00);
        tbl[4] = mk(1, 1, 32'h0C, 1, 32'h04);
        tbl[5] = mk(1, 1, 32'h10, 1, 32'h08);
        tbl[6] = mk(0, 1, 32'h14, 1, 32'h0C);
        tbl[7] = mk(0, 1, 32'h18, 1, 32'h0C);
        for (int i = 8; i < 16; i++) tbl[i] = mk(0, 0, 32'h1C, 1, 32'h0C);
        tbl[16] = mk(1, 0, 32'h1C, 1, 32'h0C);
        tbl[17] = mk(1, 1, 32'h1C, 1, 32'h10);
        tbl[18] = mk(1, 1, 32'h20, 1, 32'h14);
        tbl[19] = mk(1, 1, 32'h24, 1, 32'h18);
        tbl[20] = mk(1, 1, 32'h28, 1, 32'h1C);
        tbl[21] = mk(1, 1, 32'h2C, 1, 32'h20);

        rst_n = 1'b0;
        fen = 1'b1;
        rv = 1'b0;
        rpc = 32'h0;
        wen = 1'b1;
        rdy = 1'b1;
        li = 3'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(bus.imem_req), 32'h0);
        chk("rst_addr", bus.imem_addr, 32'h0);
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_inst", bus.out_inst, 32'h0);
        chk("rst_pc", bus.out_pc, 32'h0);
        chk("rst_wrap_addr", wbus.imem_addr, 32'hFFFF_FFF8);

        // Sequential fetch, 10-cycle backpressure, then drain.
        do_reset();
        for (int i = 0; i < 22; i++) begin
            if (i != 0) @(negedge clk);
            fen = tbl[i].fen;
            rdy = tbl[i].rdy;
            #1;
            chk($sformatf("c%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].req));
            chk($sformatf("c%0d_addr", i), bus.imem_addr, tbl[i].addr);
            chk($sformatf("c%0d_vld", i), 32'(bus.out_valid), 32'(tbl[i].vld));
            if (tbl[i].vld) begin
                chk($sformatf("c%0d_pc", i), bus.out_pc, tbl[i].pc);
                chk($sformatf("c%0d_inst", i), bus.out_inst, tbl[i].pc ^ KEY);
            end
        end

        // Redirect with three requests in flight, 3-cycle memory.
        li = 3'd2;
        do_reset();
        fen = 1'b1;
        rdy = 1'b1;
        repeat (4) @(negedge clk);
        rv = 1'b1;
        rpc = 32'h14;
        #1;
        chk("redir_req_off", 32'(bus.imem_req), 32'h0);
        chk("redir_rvalid", 32'(bus.imem_rvalid), 32'h1);
        @(negedge clk);
        rv = 1'b0;
        #1;
        wait_vld("redir_first", n);
        chk("redir_wait", n, 32'd4);
        chk("redir_pc0", bus.out_pc, 32'h14);
        chk("redir_inst0", bus.out_inst, 32'h14 ^ KEY);
        @(negedge clk);
        #1;
        chk("redir_vld1", 32'(bus.out_valid), 32'h1);
        chk("redir_pc1", bus.out_pc, 32'h18);
        chk("redir_inst1", bus.out_inst, 32'h18 ^ KEY);

        // Redirect coinciding with rvalid and a pop, 1-cycle memory.
        li = 3'd0;
        do_reset();
        fen = 1'b1;
        rdy = 1'b1;
        repeat (4) @(negedge clk);
        rv = 1'b1;
        rpc = 32'h40;
        #1;
        chk("coin_vld", 32'(bus.out_valid), 32'h1);
        chk("coin_pc", bus.out_pc, 32'h04);
        chk("coin_rvalid", 32'(bus.imem_rvalid), 32'h1);
        @(negedge clk);
        rv = 1'b0;
        #1;
        chk("coin_r1_vld", 32'(bus.out_valid), 32'h0);
        chk("coin_r1_req", 32'(bus.imem_req), 32'h1);
        chk("coin_r1_addr", bus.imem_addr, 32'h40);
        @(negedge clk);
        #1;
        chk("coin_r2_vld", 32'(bus.out_valid), 32'h0);
        @(negedge clk);
        #1;
        chk("coin_r3_vld", 32'(bus.out_valid), 32'h1);
        chk("coin_r3_pc", bus.out_pc, 32'h40);
        chk("coin_r3_inst", bus.out_inst, 32'h40 ^ KEY);
        @(negedge clk);
        #1;
        chk("coin_r4_pc", bus.out_pc, 32'h44);

        // Halt with two requests outstanding, then resume.
        li = 3'd2;
        do_reset();
        fen = 1'b1;
        rdy = 1'b1;
        repeat (2) @(negedge clk);
        fen = 1'b0;
        @(negedge clk);
        seen = 0;
        got.delete();
        gin.delete();
        for (int i = 0; i < 10; i++) begin
            #1;
            if (bus.imem_req) seen++;
            if (bus.out_valid) begin
                got.push_back(bus.out_pc);
                gin.push_back(bus.out_inst);
            end
            @(negedge clk);
        end
        chk("halt_no_req", seen, 32'd0);
        chk("halt_count", got.size(), 32'd2);
        if (got.size() == 2) begin
            chk("halt_pc0", got[0], 32'h0);
            chk("halt_pc1", got[1], 32'h4);
            chk("halt_inst1", gin[1], 32'h4 ^ KEY);
        end
        fen = 1'b1;
        #1;
        n = 0;
        while (!bus.imem_req && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("resume_req", 32'(bus.imem_req), 32'h1);
        chk("resume_addr", bus.imem_addr, 32'h8);
        wait_vld("resume_vld", n);
        chk("resume_pc", bus.out_pc, 32'h8);
        chk("resume_inst", bus.out_inst, 32'h8 ^ KEY);

        // PC wrap-around from a reset PC near the top of the space.
        do_reset();
        wen = 1'b1;
        got.delete();
        gin.delete();
        for (int i = 0; i < 12 && got.size() < 3; i++) begin
            #1;
            if (wbus.out_valid) begin
                got.push_back(wbus.out_pc);
                gin.push_back(wbus.out_inst);
            end
            @(negedge clk);
        end
        chk("wrap_count", got.size(), 32'd3);
        if (got.size() == 3) begin
            chk("wrap_pc0", got[0], 32'hFFFF_FFF8);
            chk("wrap_pc1", got[1], 32'hFFFF_FFFC);
            chk("wrap_pc2", got[2], 32'h0000_0000);
            chk("wrap_inst2", gin[2], 32'h0 ^ KEY);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the single-cycle fetch stage of the hybrid ARM/MIPS core.
- Issues pipelined in-order requests to instruction memory, buffers returned words with their PC in a prefetch FIFO, and hands them to decode over a valid/ready handshake.
- Supports a taken-branch/jump redirect that flushes the FIFO and discards in-flight responses, plus a fetch-enable for halting.

Parameters:
ADDR_W, 32, PC/address width
INST_W, 32, instruction width
PC_INC, 4, PC increment per sequential fetch
RESET_PC, 0, PC loaded on reset
DEPTH, 4, prefetch FIFO depth and maximum credits (power of 2, >=2)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  synchronous reset, active-low
fetch_en  in  1  1 = issue requests; 0 = stop issuing, keep draining
redirect_valid  in  1  branch/jump taken this cycle
redirect_pc  in  ADDR_W  target PC (replaces PCsrc/PCalu pair)
imem_req  out  1  request valid
imem_addr  out  ADDR_W  request address
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  response valid (in order, latency >=1)
imem_rdata  in  INST_W  response instruction
out_valid  out  1  instruction available to decode
out_ready  in  1  decode accepts
out_inst  out  INST_W  instruction
out_pc  out  ADDR_W  PC of out_inst

Behaviour:
- Clock/reset: one clock clk; rst_n synchronous, active-low. Reset: pc_q=RESET_PC, resp_pc=RESET_PC, state=IDLE, outstanding=0, drop_cnt=0, FIFO empty; imem_req=0, imem_addr=RESET_PC, out_valid=0, out_inst=0, out_pc=0.
- Reset mid-operation: all in-flight responses after rst_n release are NOT dropped; the system must reset memory together with the unit.
- FSM: IDLE -> RUN when fetch_en=1; RUN -> IDLE when fetch_en=0. In-flight responses still arrive in IDLE.
- Request: imem_req = (state==RUN) & !redirect_valid & (outstanding + fifo_count < DEPTH). imem_addr = pc_q. On req&gnt: pc_q += PC_INC (wraps modulo 2^ADDR_W), outstanding+1.
- Response: on rvalid, outstanding-1. If drop_cnt>0: discard, drop_cnt-1. Otherwise push {resp_pc, rdata}, resp_pc += PC_INC.
- Output: FIFO head registered; a word pushed in cycle N is visible on out_valid in N+1. Pop on out_valid&out_ready. Simultaneous push and pop are allowed when full or empty.
- Credit rule guarantees no overflow. A push into a full FIFO is an assertion failure.
- Redirect (highest priority), same cycle:
  - FIFO flushed; out_valid=0 next cycle.
  - pc_q and resp_pc <= redirect_pc; imem_req forced 0.
  - drop_cnt <= outstanding after this cycle's update; an rvalid in the redirect cycle is itself discarded.
  - A pop handshake in the redirect cycle counts as a completed transfer.
  - First request to redirect_pc is issued the next cycle, if state==RUN and credits allow.
- Back-to-back redirects: the later one wins; drop_cnt is recomputed.
- Steady state: with 1-cycle memory and out_ready=1, throughput is 1 inst/cycle; redirect-to-first-out_valid = 3 cycles.

Decomposition:
- Package fetch_pkg holds:
  - state_t enum {IDLE, RUN}
  - fetch_entry_t struct {pc, inst}
  - defaults for PC_INC and RESET_PC
- Sub-module fetch_fifo: synchronous FIFO of fetch_entry_t with flush, count output, registered head, simultaneous push/pop.

Test Plan:
- Reset and sequential fetch: rst_n=0 for 2 cycles, then fetch_en=1, 1-cycle memory, out_ready=1 -> imem_addr 0x0,0x4,0x8,... every cycle; out_pc 0x0,0x4,... with matching out_inst, one per cycle after a 2-cycle fill.
- Backpressure: out_ready=0 for 10 cycles -> exactly DEPTH=4 words buffered, imem_req drops to 0. Then out_ready=1 -> order preserved, no loss or duplication.
- Redirect with in-flight responses: 3-cycle memory latency, redirect_pc=0x14 while 3 requests are outstanding -> those 3 responses are discarded; next out_pc=0x14, then 0x18.
- Redirect coincident with rvalid and pop: all three in one cycle -> popped word counted as delivered, arriving word dropped, next out_pc=redirect_pc.
- Halt: fetch_en=0 with 2 outstanding -> no new imem_req, both responses delivered. fetch_en=1 -> fetch resumes at the next sequential PC.
- Wrap-around: RESET_PC=0xFFFFFFF8 -> out_pc 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
